// File: rtl/textram_port_arbiter.sv
// Text RAM port arbiter: one single-port RAM (registered address, unregistered q)
// shared by video scanout, an Avalon-style host and a clear/fill engine.
module textram_port_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              host_cs,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_waitrequest,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
    fill_state_t state, state_nxt;

    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] fill_ptr;
    logic [ADDR_W:0]   fill_rem;
    logic [DATA_W-1:0] fill_val;
    logic              starve_hit, vid_gnt, host_gnt, fill_gnt;
    logic              vid_vld_p1, host_vld_p1;

    // Grant stage: combinational, held off entirely while reset is asserted
    always_comb begin
        starve_hit = host_cs && (starve_cnt == CNT_W'(STARVE_MAX));
        host_gnt   = !reset && host_cs && (!vid_req || starve_hit);
        vid_gnt    = !reset && vid_req && !starve_hit;
        fill_gnt   = !reset && (state == FILL) && !vid_gnt && !host_gnt;
    end

    always_comb begin
        ram_address   = '0;
        ram_writedata = '0;
        if (vid_gnt) begin
            ram_address = vid_addr;
        end else if (host_gnt) begin
            ram_address   = host_addr;
            ram_writedata = host_wdata;
        end else if (fill_gnt) begin
            ram_address   = fill_ptr;
            ram_writedata = fill_val;
        end
    end

    assign ram_chipselect   = vid_gnt || host_gnt || fill_gnt;
    assign ram_write        = (host_gnt && host_write) || fill_gnt;
    assign ram_clken        = 1'b1;
    assign vid_ack          = vid_gnt;
    assign host_waitrequest = host_cs && !host_gnt;

    // Video wins only while the host has not yet waited STARVE_MAX video grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (!host_cs || host_gnt)
            starve_cnt <= '0;
        else if (vid_gnt)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Read return stage: q arrives one cycle after the granted address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_vld_p1  <= 1'b0;
            host_vld_p1 <= 1'b0;
        end else begin
            vid_vld_p1  <= vid_gnt;
            host_vld_p1 <= host_gnt && !host_write;
        end
    end

    assign vid_rvalid  = vid_vld_p1;
    assign host_rvalid = host_vld_p1;
    assign vid_rdata   = vid_vld_p1  ? ram_readdata : '0;
    assign host_rdata  = host_vld_p1 ? ram_readdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = (fill_len == '0) ? DONE : FILL;
            FILL:    if (fill_gnt && fill_rem == (ADDR_W+1)'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill datapath: loaded on start, advanced only on an actual fill grant
    always_ff @(posedge clk) begin
        if (state == IDLE && fill_start) begin
            fill_ptr <= fill_base;
            fill_rem <= (fill_len > FILL_MAX) ? FILL_MAX : fill_len;
            fill_val <= fill_data;
        end else if (fill_gnt) begin
            fill_ptr <= fill_ptr + ADDR_W'(1);
            fill_rem <= fill_rem - (ADDR_W+1)'(1);
        end
    end

    assign fill_busy = (state != IDLE);
    assign fill_done = (state == DONE);

endmodule

// File: doc/textram_port_arbiter.md
TEXTRAM_PORT_ARBITER -- requirements
Module: textram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning the text RAM word address width (8192 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the text RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive video grants while a host request is pending.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning an asynchronous, active-high reset.
REQ-006 SHALL have ports vid_req in 1, vid_addr in ADDR_W, vid_ack out 1, vid_rvalid out 1 and vid_rdata out DATA_W, forming the scanout read requester.
REQ-007 SHALL have ports host_cs in 1, host_write in 1, host_addr in ADDR_W, host_wdata in DATA_W, host_waitrequest out 1, host_rvalid out 1 and host_rdata out DATA_W, forming the CPU requester (Avalon-style).
REQ-008 SHALL have ports fill_start in 1, fill_base in ADDR_W, fill_len in ADDR_W+1, fill_data in DATA_W, fill_busy out 1 and fill_done out 1, forming the clear/fill engine control.
REQ-009 SHALL have ports ram_address out ADDR_W, ram_chipselect out 1, ram_write out 1, ram_writedata out DATA_W, ram_clken out 1 and ram_readdata in DATA_W, driving one RAM port with registered address and unregistered q.

Function
REQ-010 SHALL grant at most one requester per cycle, combinationally, in priority order video > host > fill, except as modified by REQ-011.
REQ-011 SHALL count consecutive video grants made while host_cs is high; when the count equals STARVE_MAX and host_cs is high, the host SHALL be granted and vid_ack SHALL be low that cycle.
REQ-012 SHALL clear the starvation count on any host grant and whenever host_cs is low.
REQ-013 SHALL assert ram_chipselect and ram_clken, and drive ram_address from the granted requester, in the grant cycle; with no grant, ram_chipselect and ram_write SHALL be 0 and ram_clken SHALL be 1.
REQ-014 SHALL assert vid_ack in a video grant cycle; vid_rvalid SHALL be 1 in the following cycle, with vid_rdata = ram_readdata (latency 1).
REQ-015 SHALL set host_waitrequest = host_cs AND NOT host-granted.
REQ-016 SHALL, on a host write grant, drive ram_write = 1 and ram_writedata = host_wdata.
REQ-017 SHALL, on a host read grant, assert host_rvalid in the next cycle, with host_rdata = ram_readdata.
REQ-018 SHALL implement the fill FSM with states IDLE, FILL and DONE.
REQ-019 SHALL, in IDLE, on fill_start: latch base, len and data; go to FILL if len != 0, else to DONE.
REQ-020 SHALL, in FILL, write fill_data at the current pointer on each fill grant, then increment the pointer modulo 2^ADDR_W and decrement the remaining count.
REQ-021 SHALL go from FILL to DONE after the grant that writes the last byte.
REQ-022 SHALL spend exactly one cycle in DONE, with fill_done = 1, then return to IDLE.
REQ-023 SHALL assert fill_busy in FILL and DONE, and SHALL ignore fill_start while fill_busy is 1.
REQ-024 SHALL request a fill grant in FILL only; fill stalls without loss while video or host hold the port.
REQ-025 SHALL accept fill_len values above 2^ADDR_W as 2^ADDR_W.
REQ-026 SHALL wrap the fill pointer from 8191 to 0.
REQ-027 SHALL, when host and fill target the same address in different cycles, leave the later-granted write in the RAM.

Reset
REQ-028 SHALL, on reset, asynchronously force: fill FSM to IDLE; starvation count, fill_busy, fill_done, vid_ack, vid_rvalid, host_rvalid, ram_chipselect and ram_write to 0; rdata outputs to 0; ram_clken to 1.
REQ-029 SHALL abandon any fill in progress on reset, leaving already-written bytes unchanged and not asserting fill_done.

Verification
REQ-030 SHALL pass: vid_req held at 1 and host read of 0x0100 pending -> video acked 3 cycles, host granted on the 4th (vid_ack = 0), host_rvalid the next cycle with the RAM byte at 0x0100.
REQ-031 SHALL pass: fill base 0x1FFE, len 4, data 0x20, no contention -> writes to 0x1FFE, 0x1FFF, 0x0000 and 0x0001 in 4 consecutive cycles, then fill_done for 1 cycle.
REQ-032 SHALL pass: fill len 0 -> no RAM write, fill_done 1 cycle after start, fill_busy high for exactly that cycle.
REQ-033 SHALL pass: fill len 16 with vid_req toggling every cycle -> exactly 16 writes, none in video-grant cycles, fill_done after the 16th.
REQ-034 SHALL pass: reset asserted mid-fill after 5 writes -> fill_busy = 0 immediately, bytes 0-4 filled, bytes 5+ unchanged, no fill_done.
REQ-035 SHALL pass: host write 0xAA to 0x0010 during a fill covering 0x0010, host granted after the fill writes 0x0010 -> readback 0xAA.
